uart_rx_cfg: RTL and testbench

//   Parametrised UART receiver: 5-9 data bits, optional odd/even parity, 1 or 2 stop bits,

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_rx_cfg.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit blocks.
//   uart_state_e : frame-level FSM states
//   PARITY_*     : parity mode codes for the PARITY parameter
//   uart_div     : clocks per oversample tick
//   uart_maj3    : 2-of-3 majority vote used for bit decisions
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    function automatic int uart_div(input int freq, input int baudrate, input int oversample);
        return freq / (baudrate * oversample);
    endfunction

    function automatic logic uart_maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator.
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   tick out one-cycle pulse every FREQ/(BAUDRATE*OVERSAMPLE) clocks
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int FREQ       = 50_000_000,
    parameter int BAUDRATE   = 19200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = uart_div(FREQ, BAUDRATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    if (DIV < 1) begin : g_bad_div
        $error("uart_baud_tick: clock too slow for BAUDRATE*OVERSAMPLE");
    end

    logic [CW-1:0] div_cnt_r;

    // Divider counter; tick is registered so it is glitch-free for the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= CNT_ZERO;
            tick      <= 1'b0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= CNT_ZERO;
            tick      <= 1'b1;
        end else begin
            div_cnt_r <= div_cnt_r + CNT_ONE;
            tick      <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5-9 data bits, none/odd/even parity,
// 1-2 stop bits, 3-sample majority vote, false-start rejection).
//   clk, rst            clock, asynchronous active-high reset
//   rx                  asynchronous serial line, idle high
//   rx_data/rx_valid    received word, held until rx_valid & rx_ready
//   rx_ready            consumer accept
//   parity_err/frame_err flags for the word in rx_data
//   overrun             one-cycle pulse when a finished frame is dropped
//   busy                FSM not idle
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int FREQ       = 50_000_000,
    parameter int BAUDRATE   = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = uart_div(FREQ, BAUDRATE, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] C_ZERO = CW'(0);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_S0   = CW'(M - 1);
    localparam logic [CW-1:0] C_S1   = CW'(M);
    localparam logic [CW-1:0] C_DEC  = CW'(M + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0] BC_DATA      = 4'(DATA_BITS);
    localparam logic [3:0] BC_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [1:0] PAR_MODE     = PARITY[1:0];
    localparam logic       PAR_TARGET   = (PAR_MODE == PARITY_ODD) ? 1'b1 : 1'b0;
    localparam logic       HAS_PARITY   = (PAR_MODE != PARITY_NONE) ? 1'b1 : 1'b0;

    if (DIV < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_rx_cfg: parameter out of range");
    end

    logic                 tick_s;
    logic                 rx_meta_r, rxs_r, rxs_prev_r;
    uart_state_e          state_r, state_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [3:0]           bit_cnt_r, bit_cnt_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic [1:0]           smp_r, smp_s;
    logic                 perr_r, perr_s, ferr_r, ferr_s;
    logic                 vote_s, done_s;

    uart_baud_tick #(
        .FREQ      (FREQ),
        .BAUDRATE  (BAUDRATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick_s)
    );

    // Two-flop synchroniser plus one delayed copy for start-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r  <= 1'b1;
            rxs_r      <= 1'b1;
            rxs_prev_r <= 1'b1;
        end else begin
            rx_meta_r  <= rx;
            rxs_r      <= rx_meta_r;
            rxs_prev_r <= rxs_r;
        end
    end

    // Frame FSM state, bit-timing counters, shift register and error accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= C_ZERO;
            bit_cnt_r <= 4'd0;
            shift_r   <= {DATA_BITS{1'b0}};
            smp_r     <= 2'b11;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            smp_r     <= smp_s;
            perr_r    <= perr_s;
            ferr_r    <= ferr_s;
        end
    end

    // Next-state logic. The bit decision at c = M+1 combines the two stored samples
    // with the live synchronised line value as the third sample.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        smp_s     = smp_r;
        perr_s    = perr_r;
        ferr_s    = ferr_r;
        done_s    = 1'b0;
        vote_s    = uart_maj3(smp_r[0], smp_r[1], rxs_r);
        if (state_r == ST_IDLE) begin
            // Only a 1->0 transition starts a frame, so a line held low never retriggers.
            if (rxs_prev_r && !rxs_r) begin
                state_s   = ST_START;
                cnt_s     = C_ZERO;
                bit_cnt_s = 4'd0;
                perr_s    = 1'b0;
                ferr_s    = 1'b0;
            end else begin
                state_s = ST_IDLE;
            end
        end else if (tick_s) begin
            cnt_s = (cnt_r == C_LAST) ? C_ZERO : cnt_r + C_ONE;
            if (cnt_r == C_S0) begin
                smp_s[0] = rxs_r;
            end else if (cnt_r == C_S1) begin
                smp_s[1] = rxs_r;
            end else begin
                smp_s = smp_r;
            end
            case (state_r)
                ST_START: begin
                    if (cnt_r == C_DEC && vote_s) begin
                        state_s = ST_IDLE;                      // false start
                    end else if (cnt_r == C_LAST) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == C_DEC) begin
                        shift_s   = {vote_s, shift_r[DATA_BITS-1:1]};
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end else if (cnt_r == C_LAST && bit_cnt_r == BC_DATA) begin
                        state_s   = HAS_PARITY ? ST_PARITY : ST_STOP;
                        bit_cnt_s = 4'd0;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (cnt_r == C_DEC) begin
                        perr_s = ((^shift_r) ^ vote_s) != PAR_TARGET;
                    end else if (cnt_r == C_LAST) begin
                        state_s = ST_STOP;
                    end else begin
                        state_s = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    // Finish mid-way through the last stop bit to leave margin for resync.
                    if (cnt_r == C_DEC) begin
                        ferr_s = ferr_r | ~vote_s;
                        if (bit_cnt_r == BC_STOP_LAST) begin
                            done_s  = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_s = ST_STOP;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = C_ZERO;
                end
            endcase
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Output register and valid/ready handshake; a frame finishing while the
    // previous word is still unaccepted is dropped and flagged as overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= {DATA_BITS{1'b0}};
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy    <= (state_s != ST_IDLE);
            overrun <= 1'b0;
            if (done_s && (!rx_valid || rx_ready)) begin
                rx_data    <= shift_r;
                rx_valid   <= 1'b1;
                parity_err <= perr_r;
                frame_err  <= ferr_s;
            end else if (done_s) begin
                overrun <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg. Three instances share one
// line driver: u_a 8N1, u_b 7E1, u_c 8N2. 64 clocks per bit, tick every 4 clocks.
module tb_uart_rx_cfg;

    localparam int FREQ     = 7_372_800;
    localparam int BAUD     = 115200;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic rx_drv   = 1'b1;
    logic rx_ready = 1'b1;
    int   sel      = 0;
    logic rx_a, rx_b, rx_c;
    assign rx_a = (sel == 0) ? rx_drv : 1'b1;
    assign rx_b = (sel == 1) ? rx_drv : 1'b1;
    assign rx_c = (sel == 2) ? rx_drv : 1'b1;

    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic valid_a, pe_a, fe_a, ov_a, busy_a;
    logic valid_b, pe_b, fe_b, ov_b, busy_b;
    logic valid_c, pe_c, fe_c, ov_c, busy_c;

    uart_rx_cfg #(.FREQ(FREQ), .BAUDRATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a), .rx_ready(rx_ready),
        .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .busy(busy_a));
    uart_rx_cfg #(.FREQ(FREQ), .BAUDRATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b), .rx_ready(rx_ready),
        .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .busy(busy_b));
    uart_rx_cfg #(.FREQ(FREQ), .BAUDRATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .rx(rx_c), .rx_data(data_c), .rx_valid(valid_c), .rx_ready(rx_ready),
        .parity_err(pe_c), .frame_err(fe_c), .overrun(ov_c), .busy(busy_c));

    // Clock count since reset release; the tick phase is fixed relative to it.
    int cyc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Handshake monitors: what each instance delivered, sampled as the DUT sees it.
    int acc_a = 0, vcyc_a = 0, ovc_a = 0, acc_b = 0, acc_c = 0;
    logic [7:0] last_a = 8'h00, last_c = 8'h00;
    logic [6:0] last_b = 7'h00;
    logic lpe_a = 1'b0, lfe_a = 1'b0, lpe_b = 1'b0, lfe_c = 1'b0;
    always @(posedge clk) begin
        if (!rst) begin
            if (valid_a) vcyc_a <= vcyc_a + 1;
            if (ov_a)    ovc_a  <= ovc_a + 1;
            if (valid_a && rx_ready) begin
                acc_a <= acc_a + 1; last_a <= data_a; lpe_a <= pe_a; lfe_a <= fe_a;
            end
            if (valid_b && rx_ready) begin
                acc_b <= acc_b + 1; last_b <= data_b; lpe_b <= pe_b;
            end
            if (valid_c && rx_ready) begin
                acc_c <= acc_c + 1; last_c <= data_c; lfe_c <= fe_c;
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bit cell. spk: invert the line for clocks 35..42 of the cell, so only the
    // third majority sample (clock 38) sees it. rdy_mid: raise rx_ready on the
    // cycle the frame completes (clock 40 of the stop cell).
    task automatic drive_bit(input logic b, input bit spk, input bit rdy_mid);
        rx_drv = b;
        if (spk) begin
            repeat (35) @(negedge clk);
            rx_drv = ~b;
            repeat (8) @(negedge clk);
            rx_drv = b;
            repeat (21) @(negedge clk);
        end else if (rdy_mid) begin
            repeat (40) @(negedge clk);
            rx_ready = 1'b1;
            repeat (24) @(negedge clk);
        end else begin
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input bit has_par, input logic pbit,
                              input logic s1, input int nstop, input logic s2, input int spike,
                              input bit rdy_stop);
        while (cyc % 4 != 0) @(negedge clk);
        drive_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i], (i == spike), 1'b0);
        if (has_par) drive_bit(pbit, 1'b0, 1'b0);
        drive_bit(s1, 1'b0, rdy_stop);
        if (nstop == 2) drive_bit(s2, 1'b0, 1'b0);
    endtask

    int a0, v0, o0;
    logic [8:0] w5a;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(valid_a), 32'd0);
        check_eq("rst_data", 32'(data_a), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_flags", {29'd0, pe_a, fe_a, ov_a}, 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // 8N1 0xA5, consumer always ready
        a0 = acc_a; v0 = vcyc_a;
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("a5_count", 32'(acc_a - a0), 32'd1);
        check_eq("a5_valid_cycles", 32'(vcyc_a - v0), 32'd1);
        check_eq("a5_data", 32'(last_a), 32'h0A5);
        check_eq("a5_flags", {30'd0, lpe_a, lfe_a}, 32'd0);
        check_eq("a5_valid_low", 32'(valid_a), 32'd0);

        // Spike on one of three samples of data bit 2
        a0 = acc_a;
        send_frame(9'h096, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1, 2, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("spike_count", 32'(acc_a - a0), 32'd1);
        check_eq("spike_data", 32'(last_a), 32'h096);

        // 16-clock low glitch in idle: false start
        a0 = acc_a;
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        check_eq("glitch_busy_hi", 32'(busy_a), 32'd1);
        rx_drv = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check_eq("glitch_busy_lo", 32'(busy_a), 32'd0);
        check_eq("glitch_no_frame", 32'(acc_a - a0), 32'd0);

        // Break: stop bit low, then line low 10 bit times
        a0 = acc_a;
        send_frame(9'h000, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, -1, 1'b0);
        repeat (10 * BIT_CLKS) @(negedge clk);
        check_eq("brk_count", 32'(acc_a - a0), 32'd1);
        check_eq("brk_data", 32'(last_a), 32'h000);
        check_eq("brk_ferr", 32'(lfe_a), 32'd1);
        rx_drv = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("post_brk_count", 32'(acc_a - a0), 32'd2);
        check_eq("post_brk_data", 32'(last_a), 32'h03C);
        check_eq("post_brk_flags", {30'd0, lpe_a, lfe_a}, 32'd0);

        // Overrun: consumer stalled across two frames
        rx_ready = 1'b0;
        a0 = acc_a; o0 = ovc_a;
        send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1, -1, 1'b0);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("ovr_valid", 32'(valid_a), 32'd1);
        check_eq("ovr_data_kept", 32'(data_a), 32'h011);
        check_eq("ovr_pulses", 32'(ovc_a - o0), 32'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        check_eq("ovr_accept_valid", 32'(valid_a), 32'd0);
        check_eq("ovr_accept_word", 32'(last_a), 32'h011);
        check_eq("ovr_accept_count", 32'(acc_a - a0), 32'd1);

        // Ready raised on the completion cycle with a word pending: no overrun
        rx_ready = 1'b0;
        a0 = acc_a; o0 = ovc_a;
        send_frame(9'h033, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1, -1, 1'b0);
        send_frame(9'h044, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1, -1, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("hold_no_ovr", 32'(ovc_a - o0), 32'd0);
        check_eq("hold_count", 32'(acc_a - a0), 32'd2);
        check_eq("hold_data", 32'(last_a), 32'h044);
        rx_ready = 1'b1;

        // 7E1: 0x41 has two ones, so the even parity bit should be 0
        sel = 1;
        repeat (4) @(negedge clk);
        send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 1, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("par1_data", 32'(last_b), 32'h041);
        check_eq("par1_perr", 32'(lpe_b), 32'd1);
        send_frame(9'h041, 7, 1'b1, 1'b0, 1'b1, 1, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("par0_perr", 32'(lpe_b), 32'd0);
        check_eq("par_count", 32'(acc_b), 32'd2);

        // 8N2: second stop bit low, then a clean frame
        sel = 2;
        repeat (4) @(negedge clk);
        send_frame(9'h055, 8, 1'b0, 1'b0, 1'b1, 2, 1'b0, -1, 1'b0);
        rx_drv = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check_eq("stop2_data", 32'(last_c), 32'h055);
        check_eq("stop2_ferr", 32'(lfe_c), 32'd1);
        send_frame(9'h0AA, 8, 1'b0, 1'b0, 1'b1, 2, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("stop2_clean_ferr", 32'(lfe_c), 32'd0);
        check_eq("stop2_count", 32'(acc_c), 32'd2);

        // Reset mid-DATA with a word pending
        sel = 0;
        repeat (4) @(negedge clk);
        rx_ready = 1'b0;
        send_frame(9'h077, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("pend_valid", 32'(valid_a), 32'd1);
        w5a = 9'h05A;
        while (cyc % 4 != 0) @(negedge clk);
        drive_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(w5a[i], 1'b0, 1'b0);
        check_eq("mid_busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        rx_drv = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(valid_a), 32'd0);
        check_eq("mid_rst_data", 32'(data_a), 32'd0);
        check_eq("mid_rst_busy", 32'(busy_a), 32'd0);
        check_eq("mid_rst_flags", {29'd0, pe_a, fe_a, ov_a}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx_ready = 1'b1;
        repeat (8) @(negedge clk);
        a0 = acc_a;
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("c3_count", 32'(acc_a - a0), 32'd1);
        check_eq("c3_data", 32'(last_a), 32'h0C3);
        check_eq("c3_flags", {30'd0, lpe_a, lfe_a}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
